// File: rtl/ioctl_sdram_bridge.sv
// Loader-to-SDRAM write bridge: FIFO-buffers ioctl words, drives the SDRAM req/ack port and reports ROM size.
// Optional Genesis header checksum check when BRIDGE_CHECKSUM_EN is defined.
module ioctl_sdram_bridge #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic        iloading,
  input  logic        iwr,
  input  logic [24:0] iaddr,
  input  logic [15:0] idata,
  output logic        owait,
  output logic [23:0] oram_addr,
  output logic [15:0] oram_data,
  output logic        oram_req,
  input  logic        iram_ack,
  output logic [24:0] orom_size,
  output logic        odone,
  output logic        ooverflow,
  output logic        ochk_ok
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 40;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] WAIT_LVL = CW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t        state, state_next;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0] count, count_next, remain_c;
  logic          loading_q;
  logic          rise_c, fall_c, push_c, pop_c, drop_c, start_c, done_c;
  logic [EW-1:0] wdata_c, head_c;
  logic [24:0]   max_addr, max_base_c;

  // FIFO bookkeeping and head selection (bypass when the pushed word lands in an empty FIFO)
  always_comb begin
    rise_c      = iloading & ~loading_q;
    fall_c      = ~iloading & loading_q;
    push_c      = iwr & iloading & (count < FULL_LVL);
    drop_c      = iwr & iloading & (count == FULL_LVL);
    pop_c       = oram_req & iram_ack;
    wdata_c     = {iaddr[24:1], idata};
    rd_ptr_next = rd_ptr + AW'(pop_c);
    count_next  = count + CW'(push_c) - CW'(pop_c);
    remain_c    = count - CW'(pop_c);
    head_c      = (remain_c == '0) ? wdata_c : mem[rd_ptr_next];
    max_base_c  = start_c ? 25'd0 : max_addr;
  end

  // Download sequencing: load, drain to SDRAM, report
  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    done_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise_c) begin
          state_next = S_LOAD;
          start_c    = 1'b1;
        end
      end
      S_LOAD: begin
        if (fall_c) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (rise_c) begin
          state_next = S_LOAD;
          start_c    = 1'b1;
        end else if (count == '0) begin
          state_next = S_DONE;
          done_c     = 1'b1;
        end
      end
      S_DONE: begin
        if (rise_c) begin
          state_next = S_LOAD;
          start_c    = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      state     <= S_IDLE;
      loading_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      owait     <= 1'b0;
      oram_req  <= 1'b0;
      oram_addr <= '0;
      oram_data <= '0;
      max_addr  <= '0;
      orom_size <= '0;
      odone     <= 1'b0;
      ooverflow <= 1'b0;
    end else begin
      state     <= state_next;
      loading_q <= iloading;
      if (push_c) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      // Raised one entry early so a write issued during the loader's reaction cycle still fits
      owait     <= (count_next >= WAIT_LVL);
      oram_req  <= (count_next != '0);
      {oram_addr, oram_data} <= (count_next != '0) ? head_c : '0;
      max_addr  <= (push_c && (iaddr > max_base_c)) ? iaddr : max_base_c;
      ooverflow <= (start_c ? 1'b0 : ooverflow) | drop_c;
      odone     <= done_c;
      if (done_c) orom_size <= max_addr + 25'd2;
    end
  end

  // Storage needs no reset: only entries below count are ever presented
  always_ff @(posedge iclk) begin
    if (push_c) mem[wr_ptr] <= wdata_c;
  end

`ifdef BRIDGE_CHECKSUM_EN
  logic [15:0] hdr_word, sum_word, hdr_base_c, sum_base_c;

  always_comb begin
    hdr_base_c = start_c ? 16'd0 : hdr_word;
    sum_base_c = start_c ? 16'd0 : sum_word;
  end

  // Header word at 0x18E against the 16-bit wrapping sum of everything from 0x200 on
  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      hdr_word <= '0;
      sum_word <= '0;
      ochk_ok  <= 1'b0;
    end else begin
      hdr_word <= (push_c && (iaddr == 25'h18E)) ? idata : hdr_base_c;
      sum_word <= (push_c && (iaddr >= 25'h200)) ? sum_base_c + idata : sum_base_c;
      if (start_c)     ochk_ok <= 1'b0;
      else if (done_c) ochk_ok <= (sum_word == hdr_word);
    end
  end
`else
  assign ochk_ok = 1'b0;
`endif

endmodule

// File: tb/tb_ioctl_sdram_bridge.sv
// Self-checking bench for ioctl_sdram_bridge: directed scenarios plus randomized loads against a queue-based model.
`timescale 1ns/1ps
module tb_ioctl_sdram_bridge;

  localparam int unsigned DEPTH = 4;
`ifdef BRIDGE_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        ireset_n, iloading, iwr, iram_ack;
  logic [24:0] iaddr;
  logic [15:0] idata;
  logic        owait, oram_req, odone, ooverflow, ochk_ok;
  logic [23:0] oram_addr;
  logic [15:0] oram_data;
  logic [24:0] orom_size;

  always #5 clk = ~clk;

  ioctl_sdram_bridge #(.DEPTH(DEPTH)) dut (
    .iclk(clk), .ireset_n(ireset_n), .iloading(iloading), .iwr(iwr),
    .iaddr(iaddr), .idata(idata), .owait(owait), .oram_addr(oram_addr),
    .oram_data(oram_data), .oram_req(oram_req), .iram_ack(iram_ack),
    .orom_size(orom_size), .odone(odone), .ooverflow(ooverflow), .ochk_ok(ochk_ok)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending SDRAM writes as a queue of {word address, data}
  logic [39:0] q[$];
  bit          m_ldp, m_load, m_drain, m_ovf, m_done, m_chk;
  logic [24:0] m_max, m_size;
  logic [15:0] m_hdr, m_sum;
  logic [15:0] rom [512];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst_n, input logic ld, input logic wr,
                            input logic [24:0] a, input logic [15:0] d, input logic ack);
    int  sz;
    bit  pop, push, drop;
    if (!rst_n) begin
      q.delete();
      m_ldp = 0; m_load = 0; m_drain = 0; m_ovf = 0; m_done = 0; m_chk = 0;
      m_max = '0; m_size = '0; m_hdr = '0; m_sum = '0;
      return;
    end
    sz   = q.size();
    pop  = (sz > 0) && ack;
    push = wr && ld && (sz < int'(DEPTH));
    drop = wr && ld && (sz == int'(DEPTH));
    m_done = 0;
    if (ld && !m_ldp) begin
      m_load = 1; m_drain = 0; m_ovf = 0; m_max = '0; m_hdr = '0; m_sum = '0; m_chk = 0;
    end else if (m_load && !ld && m_ldp) begin
      m_load = 0; m_drain = 1;
    end else if (m_drain && sz == 0) begin
      m_drain = 0; m_done = 1;
      m_size  = m_max + 25'd2;
      m_chk   = CHK_EN && (m_sum == m_hdr);
    end
    if (drop) m_ovf = 1;
    if (push) begin
      if (a > m_max) m_max = a;
      if (a == 25'h18E) m_hdr = d;
      if (a >= 25'h200) m_sum = m_sum + d;
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back({a[24:1], d});
    m_ldp = ld;
  endtask

  task automatic check_outputs();
    chk("oram_req", 64'(oram_req), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("oram_addr", 64'(oram_addr), 64'(q[0][39:16]));
      chk("oram_data", 64'(oram_data), 64'(q[0][15:0]));
    end
    chk("owait", 64'(owait), 64'(q.size() >= int'(DEPTH - 1)));
    chk("odone", 64'(odone), 64'(m_done));
    chk("ooverflow", 64'(ooverflow), 64'(m_ovf));
    chk("orom_size", 64'(orom_size), 64'(m_size));
    chk("ochk_ok", 64'(ochk_ok), 64'(m_chk));
  endtask

  task automatic cyc(input logic rst_n, input logic ld, input logic wr,
                     input logic [24:0] a, input logic [15:0] d, input logic ack);
    ireset_n = rst_n; iloading = ld; iwr = wr; iaddr = a; idata = d; iram_ack = ack;
    @(posedge clk);
    model_edge(rst_n, ld, wr, a, d, ack);
    #1;
    check_outputs();
  endtask

  // iloading low; run until a done pulse plus two quiet cycles, bounded
  task automatic drain(input int ack_pct, input string tag);
    int pulses;
    int at;
    pulses = 0;
    at = 0;
    for (int c = 0; c < 100; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 25'd0, 16'd0, $urandom_range(0, 99) < ack_pct);
      if (odone) begin
        pulses++;
        at = c;
      end
      if (pulses > 0 && c >= at + 2) break;
    end
    chk(tag, 64'(pulses), 64'd1);
  endtask

  task automatic run_load(input int nwords, input logic [24:0] start, input bit use_rom,
                          input int ack_pct, input bit obey_wait, input int wr_pct,
                          input int drain_pct, input string tag);
    int          i;
    logic [24:0] a;
    logic        w;
    i = 0;
    a = start;
    cyc(1'b1, 1'b1, 1'b0, 25'd0, 16'd0, 1'b0);
    for (int c = 0; c < 20000 && i < nwords; c++) begin
      w = ($urandom_range(0, 99) < wr_pct) && !(obey_wait && owait);
      cyc(1'b1, 1'b1, w, a, use_rom ? rom[i] : 16'($urandom), $urandom_range(0, 99) < ack_pct);
      if (w) begin
        i++;
        a = a + 25'd2;
      end
    end
    drain(drain_pct, tag);
  endtask

  initial begin
    logic [15:0] s;
    ireset_n = 1'b0; iloading = 1'b0; iwr = 1'b0; iaddr = '0; idata = '0; iram_ack = 1'b0;

    // Reset held three cycles with writes toggling
    for (int j = 0; j < 3; j++) cyc(1'b0, 1'b1, j[0], 25'(2 * j), 16'hBEEF, 1'b1);
    chk("rst_req", 64'(oram_req), 64'd0);
    chk("rst_size", 64'(orom_size), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 25'd0, 16'd0, 1'b0);

    // Streaming 8 words with ack held high
    run_load(8, 25'd0, 1'b0, 100, 1'b0, 100, 100, "stream_done");
    chk("stream_size", 64'(orom_size), 64'd16);

    // Backpressure: fill, overflow, then drain by acks while still loading
    cyc(1'b1, 1'b1, 1'b0, 25'd0, 16'd0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      cyc(1'b1, 1'b1, 1'b1, 25'(2 * j), 16'(16'hA000 + j), 1'b0);
      if (j == 2) chk("bp_owait3", 64'(owait), 64'd1);
      if (j == 3) chk("bp_no_ovf4", 64'(ooverflow), 64'd0);
      if (j == 4) chk("bp_ovf5", 64'(ooverflow), 64'd1);
    end
    for (int j = 0; j < 4; j++) begin
      if (j == 0) chk("bp_head0", 64'(oram_data), 64'hA000);
      if (j == 3) chk("bp_head3", 64'(oram_data), 64'hA003);
      cyc(1'b1, 1'b1, 1'b0, 25'd0, 16'd0, 1'b1);
    end
    chk("bp_empty", 64'(oram_req), 64'd0);
    drain(100, "bp_done");
    chk("bp_size", 64'(orom_size), 64'd8);
    chk("bp_ovf_held", 64'(ooverflow), 64'd1);

    // Simultaneous push and pop at two entries
    cyc(1'b1, 1'b1, 1'b0, 25'd0, 16'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 25'h100, 16'h1111, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 25'h102, 16'h2222, 1'b0);
    chk("pp_cleared_ovf", 64'(ooverflow), 64'd0);
    cyc(1'b1, 1'b1, 1'b1, 25'h104, 16'h3333, 1'b1);
    chk("pp_owait", 64'(owait), 64'd0);
    chk("pp_head", 64'(oram_data), 64'h2222);
    cyc(1'b1, 1'b1, 1'b1, 25'h106, 16'h4444, 1'b1);
    chk("pp_owait2", 64'(owait), 64'd0);
    chk("pp_addr", 64'(oram_addr), 64'h82);
    drain(100, "pp_done");
    chk("pp_size", 64'(orom_size), 64'h108);

    // Randomized loads, some ignoring owait to exercise drops
    for (int r = 0; r < 4; r++) begin
      run_load($urandom_range(10, 30), 25'(2 * $urandom_range(0, 2047)), 1'b0, 60,
               r[0], 70, 70, "rand_done");
      for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, 1'b1, 25'h40, 16'h5A5A, 1'b1);
    end

    // Header checksum: matching ROM, then one flipped bit
    s = '0;
    for (int j = 0; j < 512; j++) rom[j] = 16'($urandom);
    for (int j = 256; j < 512; j++) s = s + rom[j];
    rom[199] = s;
    run_load(512, 25'd0, 1'b1, 80, 1'b1, 100, 100, "chk_done");
    chk("chk_good", 64'(ochk_ok), 64'(CHK_EN));
    chk("chk_size", 64'(orom_size), 64'h400);
    rom[300] = rom[300] ^ 16'h0010;
    run_load(512, 25'd0, 1'b1, 80, 1'b1, 100, 100, "chk_done2");
    chk("chk_bad", 64'(ochk_ok), 64'd0);

    // Reset mid-load with two entries queued
    cyc(1'b1, 1'b1, 1'b0, 25'd0, 16'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 25'h20, 16'h7001, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 25'h22, 16'h7002, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 25'h24, 16'h7003, 1'b1);
    chk("mid_rst_req", 64'(oram_req), 64'd0);
    chk("mid_rst_done", 64'(odone), 64'd0);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b1, 1'b0, 1'b0, 25'd0, 16'd0, 1'b1);
      chk("mid_rst_quiet", 64'(odone), 64'd0);
    end
    run_load(3, 25'd0, 1'b0, 50, 1'b1, 100, 100, "post_rst_done");
    chk("post_rst_size", 64'(orom_size), 64'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
